// File: rtl/ps2_rx_fifo_if.sv
// Output byte stream of the PS/2 receiver: FIFO head, valid/ready handshake and occupancy.
interface ps2_rx_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       data;
    logic             valid;
    logic             ready;
    logic [LVL_W-1:0] level;

    modport master (output data, output valid, output level, input ready);
    modport slave  (input data, input valid, input level, output ready);
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with deglitched clock, frame checking, inter-bit
// watchdog and a first-word fall-through byte FIFO.
// Optional macro PS2_PARITY_CHECK_EN: when defined, odd parity is part of the
// good-frame test; when undefined only the stop bit decides.
module ps2_rx_fifo #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ps2_clk_i,
    input  logic            ps2_data_i,
    ps2_rx_fifo_if.master   bus,
    output logic            frame_err_o,
    output logic            overflow_o
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

    logic              ps2c_meta_q, ps2c_sync_q;
    logic              ps2d_meta_q, ps2d_sync_q;
    logic              filt_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic              fall_q;

    state_t            state_q;
    logic [3:0]        bit_cnt_q;
    logic [TMR_W-1:0]  timer_q;
    logic [7:0]        data_sr_q;
    logic              stop_q;
`ifdef PS2_PARITY_CHECK_EN
    logic              parity_q;
`endif
    logic              frame_err_q;
    logic              overflow_q;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;

    logic              frame_good_c;
    logic              full_c;
    logic              pop_c;
    logic              push_c;

    // Two-flop synchronisers for both pins, idling high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2c_meta_q <= 1'b1;
            ps2c_sync_q <= 1'b1;
            ps2d_meta_q <= 1'b1;
            ps2d_sync_q <= 1'b1;
        end else begin
            ps2c_meta_q <= ps2_clk_i;
            ps2c_sync_q <= ps2c_meta_q;
            ps2d_meta_q <= ps2_data_i;
            ps2d_sync_q <= ps2d_meta_q;
        end
    end

    // Clock deglitch: flip only after FILTER_LEN consecutive differing samples; strobe on 1->0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
            fall_q <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (ps2c_sync_q != filt_q) begin
                if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                    filt_q <= ps2c_sync_q;
                    fcnt_q <= '0;
                    fall_q <= ~ps2c_sync_q;
                end else begin
                    fcnt_q <= fcnt_q + FCNT_W'(1);
                end
            end else begin
                fcnt_q <= '0;
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    assign frame_good_c = stop_q & (^{parity_q, data_sr_q});
`else
    assign frame_good_c = stop_q;
`endif

    assign full_c = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop_c  = bus.valid & bus.ready;
    assign push_c = (state_q == S_CHECK) && frame_good_c && (!full_c || pop_c);

    // Frame FSM: start detect, LSB-first shift, watchdog, one-cycle check with error/overflow pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            timer_q     <= '0;
            data_sr_q   <= '0;
            stop_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= 1'b0;
`endif
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fall_q && !ps2d_sync_q) begin
                        state_q   <= S_RECV;
                        bit_cnt_q <= '0;
                        timer_q   <= '0;
                    end
                end
                S_RECV: begin
                    if (fall_q) begin
                        timer_q   <= '0;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q < 4'd8) begin
                            data_sr_q <= {ps2d_sync_q, data_sr_q[7:1]};
                        end
`ifdef PS2_PARITY_CHECK_EN
                        if (bit_cnt_q == 4'd8) begin
                            parity_q <= ps2d_sync_q;
                        end
`endif
                        if (bit_cnt_q == 4'd9) begin
                            stop_q  <= ps2d_sync_q;
                            state_q <= S_CHECK;
                        end
                    end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_IDLE;
                        timer_q     <= '0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                S_CHECK: begin
                    if (!frame_good_c) begin
                        frame_err_q <= 1'b1;
                    end else if (!push_c) begin
                        overflow_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO storage and pointers; push and pop may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= data_sr_q;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign bus.data    = mem_q[rd_ptr_q];
    assign bus.valid   = (level_q != '0);
    assign bus.level   = level_q;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;
endmodule
